// File: rtl/shift_add_multiplier_if.sv
// Handshake bundle for shift_add_multiplier: operand side (in_valid/in_ready/a/b)
// and result side (out_valid/out_ready/product), plus the busy status flag.
// master = producer/consumer side, slave = the multiplier itself.
interface shift_add_multiplier_if #(
    parameter int unsigned N = 32
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, N x N -> 2N bits.
// One partial product per BUSY cycle; result held in DONE until out_ready.
// Optional macro SHIFT_ADD_MULT_EARLY_EXIT_EN: finish as soon as no multiplier
// bits remain, giving latency 1 + index of the highest set bit of b.
module shift_add_multiplier #(
    parameter int unsigned N = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_add_multiplier_if.slave bus
);
    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state, state_nx;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [2*N-1:0] acc_sum;
    logic [2*N-1:0] prod_q;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  count;
    logic           last;
    logic           accept;

    assign accept = (state == IDLE) && bus.in_valid;

    // Partial-product sum and end-of-operation detection for the current BUSY cycle
    always_comb begin
        acc_sum = mplier[0] ? (acc + mcand) : acc;
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        // Done once the bits still to be shifted in are all zero; this makes
        // b=0 and b=1 both take a single BUSY cycle.
        last = (count == LAST) || (mplier[N-1:1] == '0);
`else
        last = (count == LAST);
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = BUSY;
            BUSY:    if (last) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand load on accept, shift/accumulate while BUSY, capture result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            prod_q <= '0;
        end else if (accept) begin
            mcand  <= {{N{1'b0}}, bus.a};
            mplier <= bus.b;
            acc    <= '0;
            count  <= '0;
        end else if (state == BUSY) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (last) begin
                prod_q <= acc_sum;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == BUSY);
    assign bus.out_valid = (state == DONE);
    assign bus.product   = prod_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: randomized and directed
// operands, scoreboard of expected products/latencies, decoupled monitor.
module tb_shift_add_multiplier;
    localparam int unsigned N = 32;

    typedef struct {
        logic [2*N-1:0] prod;
        int             lat;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rand_bp;
    logic or_rand;
    logic or_manual;

    int checks;
    int errors;
    int bcnt;
    logic ov_prev;
    exp_t q[$];

    shift_add_multiplier_if #(.N(N)) ifc ();

    shift_add_multiplier #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    assign ifc.out_ready = rand_bp ? or_rand : or_manual;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: full-width product and the number of BUSY cycles
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        e.prod = 64'(a) * 64'(b);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        e.lat = 1;
        for (int i = 0; i < int'(N); i++) begin
            if (b[i]) e.lat = i + 1;
        end
`else
        e.lat = N;
`endif
        return e;
    endfunction

    // Random output backpressure
    initial begin
        or_rand = 1'b1;
        forever begin
            @(posedge clk);
            #1 or_rand = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency on out_valid rise, product on each output handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
            bcnt    = 0;
        end else begin
            if (ifc.busy) bcnt++;
            if (ifc.out_valid && !ov_prev) begin
                if (q.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
                else chk("latency", 64'(bcnt), 64'(q[0].lat));
            end
            if (ifc.out_valid && ifc.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_product", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("product", ifc.product, e.prod);
                end
            end
            if (ifc.in_valid && ifc.in_ready) bcnt = 0;
            ov_prev = ifc.out_valid;
        end
    end

    // Present operands until accepted; expectation is queued before the accept edge
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b);
        int n;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b1;
        ifc.a = a;
        ifc.b = b;
        n = 0;
        @(negedge clk);
        while (!ifc.in_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (!ifc.in_ready) chk("accept_timeout", 64'd1, 64'd0);
        else q.push_back(model(a, b));
        @(posedge clk);
        #1 ifc.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !ifc.in_ready) && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 64'(ifc.in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(ifc.out_valid), 64'd0);
        chk({tag, "_busy"}, 64'(ifc.busy), 64'd0);
        chk({tag, "_product"}, ifc.product, 64'd0);
    endtask

    initial begin
        logic [2*N-1:0] held;
        int n;
        checks = 0;
        errors = 0;
        rand_bp = 1'b0;
        or_manual = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.a = '0;
        ifc.b = '0;
        rst_n = 1'b0;
        #2 chk_reset_vals("por");
        #20 rst_n = 1'b1;

        // Directed cases
        do_op(32'd3, 32'd5);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(32'd0, 32'h1234_5678);
        do_op(32'hDEAD_BEEF, 32'd0);
        do_op(32'd100, 32'd1);
        do_op(32'd1, 32'h8000_0000);
        wait_drain();

        // Async reset mid-cycle clears a non-zero product without a clock edge
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Backpressure in DONE, stray in_valid pulse must be ignored
        or_manual = 1'b0;
        do_op(32'h0001_0003, 32'h0000_0101);
        held = 64'(32'h0001_0003) * 64'(32'h0000_0101);
        n = 0;
        @(negedge clk);
        while (!ifc.out_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("bp_done_reached", 64'(ifc.out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                ifc.in_valid = 1'b1;
                ifc.a = 32'd5;
                ifc.b = 32'd6;
            end
            if (i == 5) ifc.in_valid = 1'b0;
            chk("bp_out_valid", 64'(ifc.out_valid), 64'd1);
            chk("bp_product_stable", ifc.product, held);
            chk("bp_in_ready", 64'(ifc.in_ready), 64'd0);
            chk("bp_busy", 64'(ifc.busy), 64'd0);
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
        or_manual = 1'b1;
        wait_drain();
        chk("product_retained_idle", ifc.product, held);

        // Reset during BUSY discards the operation
        do_op(32'd7, 32'd9);
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            if (ifc.busy) n++;
        end
        #2 rst_n = 1'b0;
        q.delete();
        #1 chk_reset_vals("rst_busy");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'd2, 32'd4);
        wait_drain();

        // Randomized operands with random output backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = rb >> $urandom_range(0, 31);
                1: ra = '1;
                2: rb = 32'd1 << $urandom_range(0, 31);
                default: ;
            endcase
            do_op(ra, rb);
        end
        wait_drain();
        rand_bp = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
